rx_frame_ctrl: RTL

Receive-side controller for the serial UART path. Synchronizes the raw serial line, detects and qualifies the start bit, and times mid-bit samples. Shifts data bits LSB-first, checks the stop bit, and drives the load_buffer/packet_data interface of the downstream 8-bit receive data buffer. Also reports framing errors and busy status to the host-side status logic.

---
 rtl/rx_pkg.sv | 16 +
 rtl/rx_bit_timer.sv | 39 +++
 rtl/rx_frame_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART receive path.
package rx_pkg;

    localparam int DATA_BITS_DEFAULT    = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECV,
        STOP_CHK,
        LOAD,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: first strobe HALF cycles after clear, then one per CLKS_PER_BIT.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int HALF         = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic sample_strobe
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable) begin
            timer_d = (timer_q == LAST) ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Timer sits at 0 on the edge-detect cycle, so HALF-1 lands HALF cycles later.
    assign sample_strobe = enable && !clear && (timer_q == HALF_M1);

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive framer: sync, start qualify, LSB-first shift, stop check, buffer load.
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 load_buffer,
    output logic                 framing_error,
    output logic                 rx_busy
);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
        $error("rx_frame_ctrl: CLKS_PER_BIT must be even and >= 4");
    end

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q,  prev_d;
    rx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 load_q,  load_d;
    logic                 fe_q,    fe_d;
    logic                 busy_q,  busy_d;

    logic s, fall, strobe, tmr_clear, tmr_enable;

    assign s    = sync2_q;
    assign fall = prev_q && !s;

    assign tmr_enable = (state_q == START_CHK) || (state_q == RECV) || (state_q == STOP_CHK);
    assign tmr_clear  = !tmr_enable;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .HALF        (CLKS_PER_BIT / 2)
    ) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (tmr_clear),
        .enable       (tmr_enable),
        .sample_strobe(strobe)
    );

    always_comb begin
        sync1_d   = serial_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        load_d    = 1'b0;
        fe_d      = fe_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START_CHK;
                    busy_d  = 1'b1;
                end
            end
            START_CHK: begin
                if (strobe) begin
                    if (s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        fe_d      = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RECV;
                    end
                end
            end
            RECV: begin
                if (strobe) begin
                    shift_d   = {s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) state_d = STOP_CHK;
                end
            end
            STOP_CHK: begin
                if (strobe) begin
                    if (s) begin
                        state_d = LOAD;
                        load_d  = 1'b1;
                    end else begin
                        // Abort: park until the line returns high so a break is not a start.
                        fe_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            LOAD: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            WAIT_IDLE: begin
                if (s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            load_q    <= 1'b0;
            fe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            load_q    <= load_d;
            fe_q      <= fe_d;
            busy_q    <= busy_d;
        end
    end

    assign packet_data   = shift_q;
    assign load_buffer   = load_q;
    assign framing_error = fe_q;
    assign rx_busy       = busy_q;

endmodule
